// File: rtl/membus_pkg.sv
// Shared types and constants for the 16-bit memory-style bus master.
package membus_pkg;
  localparam int MEMBUS_ADDR_W = 19;
  localparam int MEMBUS_DATA_W = 16;
  // Slaves store multi-word registers with the high half at the lower address.
  localparam bit HI_WORD_FIRST = 1'b1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  typedef struct packed {
    logic [2*MEMBUS_DATA_W-1:0] rdata;
    logic                       err;
  } rsp_t;
endpackage

// File: rtl/membus_timeout.sv
// Per-access done supervisor: clearable counter flagging TIMEOUT elapsed WAIT cycles.
module membus_timeout
  import membus_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int CNT_W = 10;

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt <= '0;
    end else if (en && !tc) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // tc is high during the last permitted WAIT cycle.
  assign tc = (cnt == CNT_W'(TIMEOUT - 1));
endmodule

// File: rtl/membus_split_master.sv
// Valid/ready request port to 16-bit RdMem/WrMem bus; wide requests split into two word accesses.
module membus_split_master
  import membus_pkg::*;
#(
  parameter int ADDR_W  = MEMBUS_ADDR_W,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic              req_wide,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_rd_done,
  input  logic              mem_wr_done
);
  localparam int DW = MEMBUS_DATA_W;

  state_t          state;
  logic            we_q;
  logic            wide_q;
  logic            second_q;
  logic [2*DW-1:0] wdata_q;
  logic [2*DW-1:0] rdata_q;
  logic [2*DW-1:0] rdata_nxt;
  rsp_t            rsp_q;
  logic            match;
  logic            hi_slot;
  logic            tmo;
  logic            tmo_clr;
  logic            tmo_en;

  function automatic logic [DW-1:0] word_sel(input logic [2*DW-1:0] d, input logic hi);
    return hi ? d[2*DW-1:DW] : d[DW-1:0];
  endfunction

  // Only the ack matching the current operation completes an access.
  assign match   = we_q ? mem_wr_done : mem_rd_done;
  assign hi_slot = wide_q && (second_q != HI_WORD_FIRST);
  assign tmo_clr = (state == ISSUE);
  assign tmo_en  = (state == WAIT) && !match;

  always_comb begin
    rdata_nxt = rdata_q;
    if (hi_slot) rdata_nxt[2*DW-1:DW] = mem_rdata;
    else         rdata_nxt[DW-1:0]    = mem_rdata;
  end

  membus_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tmo_clr),
    .en    (tmo_en),
    .tc    (tmo)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_q     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      we_q      <= 1'b0;
      wide_q    <= 1'b0;
      second_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (req_valid) begin
          we_q      <= req_we;
          wide_q    <= req_wide;
          second_q  <= 1'b0;
          wdata_q   <= req_wdata;
          rdata_q   <= '0;
          mem_addr  <= req_addr;
          mem_wdata <= word_sel(req_wdata, req_wide && HI_WORD_FIRST);
          mem_rd    <= !req_we;
          mem_wr    <= req_we;
          req_ready <= 1'b0;
          state     <= ISSUE;
        end
        ISSUE: begin
          mem_rd <= 1'b0;
          mem_wr <= 1'b0;
          state  <= WAIT;
        end
        WAIT: begin
          if (match) begin
            if (!we_q) rdata_q <= rdata_nxt;
            if (wide_q && !second_q) begin
              second_q  <= 1'b1;
              mem_addr  <= mem_addr + ADDR_W'(1);
              mem_wdata <= word_sel(wdata_q, !HI_WORD_FIRST);
              mem_rd    <= !we_q;
              mem_wr    <= we_q;
              state     <= ISSUE;
            end else begin
              rsp_q     <= '{rdata: (we_q ? '0 : rdata_nxt), err: 1'b0};
              rsp_valid <= 1'b1;
              state     <= RESP;
            end
          end else if (tmo) begin
            // Abandon any remaining word; halves never received stay zero.
            rsp_q     <= '{rdata: rdata_q, err: 1'b1};
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          rsp_valid <= 1'b0;
          rsp_q     <= '0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rsp_rdata = rsp_q.rdata;
  assign rsp_err   = rsp_q.err;
endmodule

// File: tb/tb_membus_split_master.sv
// Randomized scoreboard bench for membus_split_master with a behavioural slave and reference model.
module tb_membus_split_master;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_wide;
  logic [18:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [18:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic        mem_rd, mem_wr, mem_rd_done, mem_wr_done;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  membus_split_master #(.ADDR_W(19), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_wide(req_wide),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata), .mem_rd_done(mem_rd_done), .mem_wr_done(mem_wr_done)
  );

  typedef struct { int lat; bit wrong; bit both; } plan_t;
  typedef struct { logic [31:0] rdata; logic err; int cyc; } exp_t;

  plan_t      plan_q[$];
  exp_t       exp_q[$];
  logic [15:0] smem [int];
  logic [15:0] rmem [int];
  int exp_strobes = 0;
  int strobes = 0;
  int checks = 0;
  int errors = 0;
  int rst_chk_req = 0;
  int tmo_req = 0;
  bit final_req = 1'b0;

  // Background contents of the slave memory for never-written words.
  function automatic logic [15:0] bg(input int a);
    case (a)
      0: return 16'h1234;
      1: return 16'hDEAD;
      2: return 16'hBEEF;
      default: return 16'(a * 40503) ^ 16'h5A5A;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  // Slave: lat = WAIT cycle carrying the ack, 0 = never acks; wrong/both add foreign acks.
  initial begin
    plan_t p;
    int k;
    bit active;
    bit rd_op;
    logic [15:0] rv;
    mem_rd_done = 1'b0; mem_wr_done = 1'b0; mem_rdata = '0;
    active = 1'b0; k = 0; rd_op = 1'b0; rv = '0; p = '{1, 1'b0, 1'b0};
    forever begin
      @(posedge clk); #2;
      mem_rd_done = 1'b0; mem_wr_done = 1'b0; mem_rdata = 16'($urandom);
      if (mem_rd || mem_wr) begin
        strobes++;
        if (plan_q.size() > 0) p = plan_q.pop_front();
        else p = '{1, 1'b0, 1'b0};
        rd_op = mem_rd;
        if (mem_wr) smem[int'(mem_addr)] = mem_wdata;
        rv = smem.exists(int'(mem_addr)) ? smem[int'(mem_addr)] : bg(int'(mem_addr));
        k = 0; active = 1'b1;
      end else if (active) begin
        k++;
        if (k == p.lat) begin
          mem_rdata = rv;
          if (rd_op) mem_rd_done = 1'b1; else mem_wr_done = 1'b1;
          if (p.both) begin
            if (rd_op) mem_wr_done = 1'b1; else mem_rd_done = 1'b1;
          end
          active = 1'b0;
        end else begin
          if (p.wrong && k == 1) begin
            if (rd_op) mem_wr_done = 1'b1; else mem_rd_done = 1'b1;
          end
          if (p.lat == 0) active = 1'b0;
        end
      end else if (rst_n && req_ready && !req_valid && $urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 1) mem_rd_done = 1'b1; else mem_wr_done = 1'b1;
      end
    end
  end

  // Issue one request; the expected response follows from the per-word ack plan.
  task automatic do_req(input bit we, input bit wide, input logic [18:0] addr,
                        input logic [31:0] wd, input int l0, input int l1,
                        input bit wrong, input bit both, input bit expect_rsp);
    int lats[2];
    logic [15:0] v[2];
    logic [18:0] a;
    logic [15:0] wdw;
    bit err, late, ok, got;
    int tot, n, w;
    exp_t e;
    w = 0;
    while (!req_ready && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    if (!req_ready) begin
      tmo_req++;
      return;
    end
    lats[0] = l0; lats[1] = l1; v[0] = '0; v[1] = '0;
    err = 1'b0; late = 1'b0; tot = 0; n = wide ? 2 : 1;
    for (int i = 0; i < n; i++) begin
      a = addr + 19'(i);
      wdw = (wide && i == 0) ? wd[31:16] : wd[15:0];
      plan_q.push_back('{lats[i], wrong, both});
      exp_strobes++;
      if (we) rmem[int'(a)] = wdw;
      ok = (lats[i] >= 1 && lats[i] <= TO);
      if (lats[i] > TO) late = 1'b1;
      if (!we && ok) v[i] = rmem.exists(int'(a)) ? rmem[int'(a)] : bg(int'(a));
      tot += 1 + (ok ? lats[i] : TO);
      if (!ok) begin
        err = 1'b1;
        break;
      end
    end
    tot += 1;
    e.rdata = we ? 32'h0 : (wide ? {v[0], v[1]} : {16'h0, v[0]});
    e.err = err;
    e.cyc = cyc + tot;
    if (expect_rsp) exp_q.push_back(e);
    req_we = we; req_wide = wide; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (expect_rsp) begin
      got = 1'b0;
      for (int i = 0; i < 200; i++) begin
        @(posedge clk); #1;
        if (rsp_valid) begin
          got = 1'b1;
          break;
        end
      end
      if (!got) tmo_req++;
      repeat (late ? 5 : $urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end
  endtask

  function automatic int pick_lat();
    int r;
    r = $urandom_range(0, 19);
    if (r == 0) return 0;
    if (r == 1) return 6;
    return $urandom_range(1, TO);
  endfunction

  function automatic logic [18:0] pick_addr();
    if ($urandom_range(0, 1) == 1) return 19'($urandom_range(0, 15));
    return 19'h7FFF0 + 19'($urandom_range(0, 15));
  endfunction

  // Stimulus
  initial begin
    req_valid = 1'b0; req_we = 1'b0; req_wide = 1'b0; req_addr = '0; req_wdata = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_chk_req++;
    @(posedge clk); #1;
    rst_n = 1'b1;

    do_req(1'b0, 1'b0, 19'h00000, 32'h0, 1, 1, 1'b0, 1'b0, 1'b1);
    do_req(1'b0, 1'b1, 19'h00001, 32'h0, 1, 1, 1'b0, 1'b0, 1'b1);
    do_req(1'b1, 1'b1, 19'h7FFFF, 32'hCAFE0001, 1, 1, 1'b0, 1'b0, 1'b1);
    do_req(1'b0, 1'b1, 19'h7FFFF, 32'h0, 2, 3, 1'b0, 1'b0, 1'b1);
    do_req(1'b0, 1'b0, 19'h00005, 32'h0, 0, 1, 1'b0, 1'b0, 1'b1);
    do_req(1'b0, 1'b0, 19'h00006, 32'h0, 6, 1, 1'b0, 1'b0, 1'b1);
    do_req(1'b0, 1'b0, 19'h00007, 32'h0, 3, 1, 1'b1, 1'b0, 1'b1);
    do_req(1'b0, 1'b0, 19'h00008, 32'h0, 2, 1, 1'b0, 1'b1, 1'b1);
    do_req(1'b1, 1'b0, 19'h00009, 32'h00005A5A, 4, 1, 1'b1, 1'b1, 1'b1);
    do_req(1'b0, 1'b1, 19'h00003, 32'h0, 1, 0, 1'b0, 1'b0, 1'b1);

    // Reset during the second word's WAIT of a wide write; its late ack lands in IDLE.
    do_req(1'b1, 1'b1, 19'h0000A, 32'h11112222, 1, 3, 1'b0, 1'b0, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    rst_chk_req++;
    repeat (4) begin
      @(posedge clk); #1;
    end
    do_req(1'b0, 1'b0, 19'h0000A, 32'h0, 1, 1, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 250; i++) begin
      do_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pick_addr(), $urandom,
             pick_lat(), pick_lat(), ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0), 1'b1);
    end

    repeat (3) @(posedge clk);
    final_req = 1'b1;
    repeat (5) @(posedge clk);
  end

  // Monitor / scoreboard
  initial begin
    bit prev;
    exp_t e;
    int rdone, tdone;
    prev = 1'b0; rdone = 0; tdone = 0;
    forever begin
      @(negedge clk);
      if (cyc > 60000) begin
        $display("FAIL watchdog: got cycle %0d expected below 60000", cyc);
        $fatal(1);
      end
      if (rst_chk_req != rdone) begin
        rdone++;
        chk("reset req_ready", 32'(req_ready), 32'd1);
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset rsp_err", 32'(rsp_err), 32'd0);
        chk("reset rsp_rdata", rsp_rdata, 32'd0);
        chk("reset mem_addr", 32'(mem_addr), 32'd0);
        chk("reset mem_wdata", 32'(mem_wdata), 32'd0);
        chk("reset mem_rd", 32'(mem_rd), 32'd0);
        chk("reset mem_wr", 32'(mem_wr), 32'd0);
      end
      if (prev) chk("ready after resp", 32'(req_ready), 32'd1);
      if (tmo_req != tdone) begin
        tdone++;
        checks++;
        errors++;
        $display("FAIL handshake wait: got no DUT handshake expected one within bound");
      end
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected rsp: got rdata %0h err %0d expected no response", rsp_rdata, rsp_err);
        end else begin
          e = exp_q.pop_front();
          chk("rsp rdata", rsp_rdata, e.rdata);
          chk("rsp err", 32'(rsp_err), 32'(e.err));
          chk("rsp cycle", 32'(cyc), 32'(e.cyc));
        end
      end
      prev = rsp_valid;
      if (final_req) begin
        chk("strobe count", 32'(strobes), 32'(exp_strobes));
        chk("pending responses", 32'(exp_q.size()), 32'd0);
        foreach (rmem[k]) begin
          chk($sformatf("mem word %0h", k), 32'(smem.exists(k) ? smem[k] : bg(k)), 32'(rmem[k]));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
      end
    end
  end
endmodule
